// File: rtl/i2c.sv
// Single-master I2C controller: one addressed single-byte write or read per request,
// with SCL derived from the system clock by a quarter-period divider.
module i2c #(
  parameter int QTR_CYCLES = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       r_w,
  input  logic       start_cond,
  input  logic [6:0] s_add,
  input  logic [7:0] data,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

  localparam int QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;

  state_t          state, state_nxt;
  logic [QW-1:0]   qcnt;
  logic [1:0]      quarter;
  logic [2:0]      bit_cnt;
  logic            start_q;
  logic            rw_l;
  logic [7:0]      data_l;
  logic [7:0]      shift;
  logic [7:0]      rx_shift;
  logic            sda_smp;
  logic            sda_low;
  logic            start_edge;
  logic            q_end;
  logic            sample;
  logic            slot_end;

  assign start_edge = start_cond & ~start_q;
  assign q_end      = (qcnt == QW'(QTR_CYCLES - 1));
  assign sample     = q_end && (quarter == 2'd2);
  assign slot_end   = q_end && (quarter == 2'd3);
  assign busy       = (state != IDLE);

  // Open-drain: only ever pull low; a released line is lifted by the external pull-up.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    scl       = 1'b1;
    sda_low   = 1'b0;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: begin
        sda_low = quarter[1];
        if (slot_end) state_nxt = ADDR;
      end
      ADDR: begin
        scl     = quarter[1];
        sda_low = ~shift[7];
        if (slot_end && bit_cnt == 3'd7) state_nxt = ACK1;
      end
      ACK1: begin
        scl = quarter[1];
        if (slot_end) state_nxt = sda_smp ? STOP : DATA;
      end
      DATA: begin
        scl     = quarter[1];
        sda_low = ~rw_l & ~shift[7];
        if (slot_end && bit_cnt == 3'd7) state_nxt = ACK2;
      end
      ACK2: begin
        scl = quarter[1];
        if (slot_end) state_nxt = STOP;
      end
      STOP: begin
        scl     = quarter[1];
        sda_low = (quarter != 2'd3);
        if (slot_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every flop reading pre-edge values,
  // so the order of statements below does not change the hardware.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      qcnt     <= '0;
      quarter  <= 2'd0;
      bit_cnt  <= 3'd0;
      start_q  <= 1'b0;
      rw_l     <= 1'b0;
      data_l   <= 8'h00;
      shift    <= 8'h00;
      rx_shift <= 8'h00;
      sda_smp  <= 1'b1;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      state   <= state_nxt;
      start_q <= start_cond;
      done    <= 1'b0;
      if (state == IDLE) begin
        qcnt    <= '0;
        quarter <= 2'd0;
        bit_cnt <= 3'd0;
        if (start_edge) begin
          shift   <= {s_add, r_w};
          rw_l    <= r_w;
          data_l  <= data;
          ack_err <= 1'b0;
        end
      end else begin
        qcnt <= q_end ? '0 : qcnt + 1'b1;
        if (q_end) quarter <= quarter + 2'd1;
        if (sample) begin
          sda_smp <= sda;
          if (state == DATA) rx_shift <= {rx_shift[6:0], sda};
        end
        if (slot_end) begin
          case (state)
            ADDR: begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
            ACK1: begin
              if (sda_smp) ack_err <= 1'b1;
              else         shift   <= data_l;
            end
            DATA: begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              // rx_shift already holds bit 0, sampled in Q2 of this last slot.
              if (bit_cnt == 3'd7 && rw_l) rd_data <= rx_shift;
            end
            ACK2:    if (!rw_l && sda_smp) ack_err <= 1'b1;
            STOP:    done <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c.sv
// Bench for i2c: bus monitor plus slave model on the open-drain lines, a table of
// transactions checked against a bit-level reference model, and hand-written corner cases.
module tb_i2c;

  localparam int QTR  = 5;
  localparam int SLOT = 4 * QTR;
  localparam int NVEC = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       r_w = 1'b0;
  logic       start_cond = 1'b0;
  logic [6:0] s_add = 7'h00;
  logic [7:0] data = 8'h00;
  logic       scl, busy, done, ack_err;
  logic [7:0] rd_data;
  wire        sda;

  logic slave_low = 1'b0;
  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c #(.QTR_CYCLES(QTR)) dut (
    .clock(clock), .reset(reset), .r_w(r_w), .start_cond(start_cond),
    .s_add(s_add), .data(data), .scl(scl), .sda(sda), .busy(busy),
    .done(done), .ack_err(ack_err), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus monitor and slave model ----------------
  bit         prev_scl = 1'b1, prev_sda = 1'b1;
  int         starts = 0, stops = 0, rises = 0;
  bit         obs_bits[$];
  bit         s_en = 1'b0, s_ack_data = 1'b1, s_read = 1'b0, in_xfer = 1'b0;
  logic [7:0] s_rdata = 8'h00;

  // Decides what the slave drives for the bit that follows the given count of SCL rises.
  function automatic bit slave_drive(input int n);
    if (!s_en) return 1'b0;
    if (n == 8) return 1'b1;
    if (s_read) begin
      if (n >= 9 && n <= 16) return !s_rdata[16 - n];
      return 1'b0;
    end
    if (n == 17) return s_ack_data;
    return 1'b0;
  endfunction

  always @(negedge clock) begin
    bit c_scl, c_sda;
    c_scl = scl;
    c_sda = (sda == 1'b0) ? 1'b0 : 1'b1;
    if (!reset) begin
      slave_low = 1'b0;
      in_xfer   = 1'b0;
    end else begin
      if (prev_scl && c_scl && prev_sda && !c_sda) begin
        starts++; in_xfer = 1'b1; rises = 0; slave_low = 1'b0;
      end else if (prev_scl && c_scl && !prev_sda && c_sda) begin
        stops++; in_xfer = 1'b0; slave_low = 1'b0;
      end
      if (!prev_scl && c_scl) begin
        obs_bits.push_back(c_sda);
        rises++;
        if (rises == 8) s_read = c_sda;
      end
      if (prev_scl && !c_scl && in_xfer) slave_low = slave_drive(rises);
    end
    prev_scl = c_scl;
    prev_sda = c_sda;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0] s_add;
    logic       r_w;
    logic [7:0] data;
    bit         slave_en;
    bit         ack_data;
    logic [7:0] rdata;
    int         exp_cycles;
    bit         exp_err;
  } vec_t;

  vec_t       vecs[NVEC];
  bit         exp_bits[$];
  logic [7:0] model_rd = 8'h00;

  // Bits a bus observer sees on SCL rises, the transaction length and the error flag.
  function automatic void model(input vec_t v, output int cyc, output bit err);
    logic [7:0] addr_byte, byte_v;
    addr_byte = {v.s_add, v.r_w};
    exp_bits.delete();
    for (int i = 7; i >= 0; i--) exp_bits.push_back(addr_byte[i]);
    exp_bits.push_back(!v.slave_en);
    if (!v.slave_en) begin
      exp_bits.push_back(1'b0);
      cyc = 11 * SLOT;
      err = 1'b1;
      return;
    end
    byte_v = v.r_w ? v.rdata : v.data;
    for (int i = 7; i >= 0; i--) exp_bits.push_back(byte_v[i]);
    exp_bits.push_back(v.r_w ? 1'b1 : !v.ack_data);
    exp_bits.push_back(1'b0);
    cyc = 20 * SLOT;
    err = !v.r_w && !v.ack_data;
  endfunction

  // toggle: extra start_cond edges while busy, leaving it high after the end.
  task automatic run_txn(input vec_t v, input bit chain_next, input bit toggle);
    int cyc, exp_cyc, mism;
    bit exp_err, chained;
    logic [7:0] exp_rd;
    model(v, exp_cyc, exp_err);
    exp_rd   = (v.slave_en && v.r_w) ? v.rdata : model_rd;
    model_rd = exp_rd;
    chained  = start_cond;
    s_add = v.s_add; r_w = v.r_w; data = v.data;
    s_en = v.slave_en; s_ack_data = v.ack_data; s_rdata = v.rdata;
    obs_bits.delete();
    starts = 0; stops = 0;
    if (!chained) begin
      @(negedge clock);
      start_cond = 1'b1;
    end
    @(posedge clock); #1;
    check("busy_on", busy, 1);
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 20) start_cond = 1'b0;
      if (toggle && cyc == 60)  start_cond = 1'b1;
      if (toggle && cyc == 70)  start_cond = 1'b0;
      if (toggle && cyc == 150) start_cond = 1'b1;
      if (done) break;
    end
    check("done_seen", done, 1);
    check("cycles", cyc, v.exp_cycles);
    check("busy_off", busy, 0);
    check("ack_err", ack_err, v.exp_err);
    check("rd_data", rd_data, exp_rd);
    check("bit_count", obs_bits.size(), exp_bits.size());
    mism = 0;
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++)
      if (obs_bits[i] != exp_bits[i]) mism++;
    check("bits", mism, 0);
    check("starts", starts, 1);
    check("stops", stops, 1);
    if (chain_next) start_cond = 1'b1;
    else begin
      @(posedge clock); #1;
      check("done_pulse", done, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int busy_hits;
    int cyc;
    bit err;

    vecs[0] = '{7'b1110101, 1'b0, 8'hE9, 1'b1, 1'b1, 8'h00, 400, 1'b0};
    vecs[1] = '{7'b1110101, 1'b0, 8'hE9, 1'b0, 1'b1, 8'h00, 220, 1'b1};
    vecs[2] = '{7'h50,      1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 400, 1'b0};
    vecs[3] = '{7'h2A,      1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 400, 1'b1};
    vecs[4] = '{7'h50,      1'b1, 8'h00, 1'b0, 1'b1, 8'h5A, 220, 1'b1};
    for (int i = 5; i < NVEC; i++) begin
      vecs[i].s_add    = 7'($urandom);
      vecs[i].r_w      = 1'($urandom);
      vecs[i].data     = 8'($urandom);
      vecs[i].slave_en = ($urandom_range(0, 3) != 0);
      vecs[i].ack_data = ($urandom_range(0, 3) != 0);
      vecs[i].rdata    = 8'($urandom);
      model(vecs[i], cyc, err);
      vecs[i].exp_cycles = cyc;
      vecs[i].exp_err    = err;
    end

    // Reset held for 10 clocks (10 us at 1 MHz), then released.
    repeat (10) @(posedge clock);
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("idle_scl", scl, 1);
    check("idle_sda", sda, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ack_err", ack_err, 0);
    check("idle_rd_data", rd_data, 8'h00);

    for (int i = 0; i < NVEC; i++) run_txn(vecs[i], 1'b0, 1'b0);

    // New request raised on the very clock done pulses.
    run_txn(vecs[0], 1'b1, 1'b0);
    run_txn(vecs[2], 1'b0, 1'b0);

    // Edges while busy are ignored; a level held across the end does not retrigger.
    run_txn(vecs[0], 1'b0, 1'b1);
    starts = 0;
    busy_hits = 0;
    repeat (60) begin
      @(posedge clock); #1;
      if (busy) busy_hits++;
    end
    check("no_retrigger_busy", busy_hits, 0);
    check("no_retrigger_start", starts, 0);
    @(negedge clock) start_cond = 1'b0;
    repeat (3) @(posedge clock);

    // Reset in the middle of a write DATA phase.
    s_add = 7'h33; r_w = 1'b0; data = 8'h5A; s_en = 1'b1; s_ack_data = 1'b1;
    @(negedge clock) start_cond = 1'b1;
    @(posedge clock);
    repeat (20) @(posedge clock);
    start_cond = 1'b0;
    repeat (250) @(posedge clock);
    #1;
    check("mid_busy", busy, 1);
    #1;
    reset = 1'b0;
    #1;
    check("async_scl", scl, 1);
    check("async_sda", sda, 1);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_rd_data", rd_data, 8'h00);
    model_rd = 8'h00;
    @(negedge clock) reset = 1'b1;
    repeat (3) @(posedge clock);
    run_txn(vecs[0], 1'b0, 1'b0);
    run_txn(vecs[2], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
